// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer for the five-stage MIPS pipeline.
// Turns a load/store in M into a req/ack transaction on a multi-cycle memory
// port. It stalls the front of the pipeline and bubbles MEM/WB while the
// transaction is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT cycles without ack and raise the sticky MemErr flag.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              FlushW,
  output logic              MemErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  logic access_req;
  assign access_req = MemReadM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state and datapath latch decisions for the access sequencer.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    read_data_d = read_data_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // mem_ack is deliberately ignored here; a stray ack cannot complete anything.
        if (access_req) begin
          mem_addr_d  = ALUOutM;
          mem_wdata_d = WriteDataM;
          mem_we_d    = MemWriteM;   // write wins when both are set
          mem_req_d   = 1'b1;
          state_d     = S_BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          // An ack in the last allowed cycle still completes normally.
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            read_data_d = mem_rdata;
          end
          state_d = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          read_data_d = '0;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        // Request inputs still show the completed instruction; never re-issue it.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-port outputs; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      read_data_q <= read_data_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // BUSY-cycle counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign MemErr = err_q;
`else
  assign MemErr = 1'b0;
`endif

  // Stall is combinational so the instruction in M is held in the same cycle it is seen.
  assign StallM = ~reset & (((state_q == S_IDLE) & access_req) | (state_q == S_BUSY));
  // W drains while M is held, so bubble MEM/WB whenever M stalls.
  assign FlushW = StallM;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ReadDataM = read_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl (default 32-bit build).
// Each table row is one clock cycle: inputs driven after the falling edge,
// outputs compared 1 ns later, before the next rising edge.
module tb_mem_access_ctrl;

  localparam int OW = 5 + 3 * 32;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, FlushW, MemErr;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .FlushW     (FlushW),
    .MemErr     (MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rdout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                             logic ack, logic [31:0] rdata,
                             logic es, logic er, logic ew,
                             logic [31:0] ea, logic [31:0] ewd, logic [31:0] erd);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.ack = ack; r.rdata = rdata;
    r.e_stall = es; r.e_req = er; r.e_we = ew;
    r.e_addr = ea; r.e_wdata = ewd; r.e_rdout = erd;
    return r;
  endfunction

  function automatic logic [OW-1:0] expv(logic s, logic r, logic w, logic e,
                                         logic [31:0] a, logic [31:0] wd, logic [31:0] rdo);
    return {s, s, r, w, e, a, wd, rdo};
  endfunction

  function automatic logic [OW-1:0] actv();
    return {StallM, FlushW, mem_req, mem_we, MemErr, mem_addr, mem_wdata, ReadDataM};
  endfunction

  // Fields printed as {stall,flush,req,we,err}_addr_wdata_rdata.
  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got ctl=%b addr=%h wdata=%h rdata=%h, want ctl=%b addr=%h wdata=%h rdata=%h",
               name, act[OW-1 -: 5], act[95:64], act[63:32], act[31:0],
               exp[OW-1 -: 5], exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
    MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = wdata;
    mem_ack = ack; mem_rdata = rdata;
  endtask

`ifdef MEM_TIMEOUT_EN
  // Load with no ack (ack_cycle = 0) or ack in BUSY cycle ack_cycle.
  task automatic run_timeout(input int ack_cycle);
    logic [31:0] want_rd;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // Prime ReadDataM with a non-zero value so the abort's zeroing is visible.
    drive(1, 0, 32'h3FC, 0, 0, 0);
    @(negedge clk); drive(1, 0, 32'h3FC, 0, 1, 32'h0BAD_F00D);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 32'h400, 0, 0, 0);
    #1 chk("to_issue", actv(), expv(1, 0, 0, 0, 32'h3FC, 0, 32'h0BAD_F00D));
    for (int b = 1; b <= 15; b++) begin
      @(negedge clk);
      drive(1, 0, 32'h400, 0, (b == ack_cycle), 32'h5555_AAAA);
      #1 chk($sformatf("to_busy%0d", b), actv(), expv(1, 1, 0, 0, 32'h400, 0, 32'h0BAD_F00D));
    end
    @(negedge clk); drive(1, 0, 32'h400, 0, 0, 0);
    want_rd = (ack_cycle != 0) ? 32'h5555_AAAA : 32'h0;
    #1 chk("to_done", actv(), expv(0, 0, 0, ack_cycle == 0, 32'h400, 0, want_rd));
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk("to_sticky", actv(), expv(0, 0, 0, ack_cycle == 0, 32'h400, 0, want_rd));
  endtask
`endif

  initial begin
    // Stimulus table: one row per cycle.
    // Load @0x40, ack at t+1.
    vecs.push_back(v(1,0,32'h40,0,0,0,                       1,0,0,32'h40*0,0,0));
    vecs.push_back(v(1,0,32'h40,0,1,32'hDEAD_BEEF,           1,1,0,32'h40,0,0));
    vecs.push_back(v(1,0,32'h40,0,0,0,                       0,0,0,32'h40,0,32'hDEAD_BEEF));
    vecs.push_back(v(0,0,0,0,0,0,                            0,0,0,32'h40,0,32'hDEAD_BEEF));
    // Stray ack in IDLE.
    vecs.push_back(v(0,0,0,0,1,32'hCCCC_0000,                0,0,0,32'h40,0,32'hDEAD_BEEF));
    // Store @0x80, ack in 4th BUSY cycle; read data on the bus must not be captured.
    vecs.push_back(v(0,1,32'h80,32'h1234_5678,0,0,           1,0,0,32'h40,0,32'hDEAD_BEEF));
    vecs.push_back(v(0,1,32'h80,32'h1234_5678,0,0,           1,1,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    vecs.push_back(v(0,1,32'h80,32'h1234_5678,0,0,           1,1,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    vecs.push_back(v(0,1,32'h80,32'h1234_5678,0,0,           1,1,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    vecs.push_back(v(0,1,32'h80,32'h1234_5678,1,32'hFFFF_FFFF,1,1,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    vecs.push_back(v(0,1,32'h80,32'h1234_5678,0,0,           0,0,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    vecs.push_back(v(0,0,0,0,0,0,                            0,0,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    // Read and write both set: single write.
    vecs.push_back(v(1,1,32'h100,32'hA5A5_A5A5,0,0,          1,0,1,32'h80,32'h1234_5678,32'hDEAD_BEEF));
    vecs.push_back(v(1,1,32'h100,32'hA5A5_A5A5,1,32'h1111_1111,1,1,1,32'h100,32'hA5A5_A5A5,32'hDEAD_BEEF));
    vecs.push_back(v(1,1,32'h100,32'hA5A5_A5A5,0,0,          0,0,1,32'h100,32'hA5A5_A5A5,32'hDEAD_BEEF));
    // Back-to-back loads; ack during the second DONE is dropped.
    vecs.push_back(v(1,0,32'h200,0,0,0,                      1,0,1,32'h100,32'hA5A5_A5A5,32'hDEAD_BEEF));
    vecs.push_back(v(1,0,32'h200,0,1,32'hAAAA_0001,          1,1,0,32'h200,0,32'hDEAD_BEEF));
    vecs.push_back(v(1,0,32'h200,0,0,0,                      0,0,0,32'h200,0,32'hAAAA_0001));
    vecs.push_back(v(1,0,32'h204,0,0,0,                      1,0,0,32'h200,0,32'hAAAA_0001));
    vecs.push_back(v(1,0,32'h204,0,1,32'hBBBB_0002,          1,1,0,32'h204,0,32'hAAAA_0001));
    vecs.push_back(v(1,0,32'h204,0,1,32'hEEEE_0003,          0,0,0,32'h204,0,32'hBBBB_0002));
    vecs.push_back(v(0,0,0,0,0,0,                            0,0,0,32'h204,0,32'hBBBB_0002));

    // Reset with a request present: everything zero, stall forced low.
    reset = 1'b1;
    drive(1, 0, 32'h40, 0, 1, 32'h1);
    @(negedge clk);
    #1 chk("reset_state", actv(), expv(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("post_reset_idle", actv(), expv(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
      #1 chk($sformatf("vec%0d", i), actv(),
             expv(vecs[i].e_stall, vecs[i].e_req, vecs[i].e_we, 1'b0,
                  vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rdout));
    end

    // Reset asserted in the 2nd BUSY cycle, then a late ack.
    @(negedge clk); drive(1, 0, 32'h300, 32'h0, 0, 0);
    @(negedge clk);
    #1 chk("rst_busy1", actv(), expv(1, 1, 0, 0, 32'h300, 0, 32'hBBBB_0002));
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_async", actv(), expv(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h7777_7777);
    #1 chk("rst_late_ack", actv(), expv(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1 chk("rst_still_idle", actv(), expv(0, 0, 0, 0, 0, 0, 0));
    // A fresh load proves the FSM is back in IDLE.
    @(negedge clk); drive(1, 0, 32'h308, 0, 0, 0);
    #1 chk("rst_reissue_stall", actv(), expv(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(1, 0, 32'h308, 0, 1, 32'h0123_4567);
    #1 chk("rst_reissue_busy", actv(), expv(1, 1, 0, 0, 32'h308, 0, 0));
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1 chk("rst_reissue_done", actv(), expv(0, 0, 0, 0, 32'h308, 0, 32'h0123_4567));

`ifdef MEM_TIMEOUT_EN
    run_timeout(0);
    run_timeout(15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
